// File: rtl/jpeg_byte_stuffer.sv
// Packs right-aligned Huffman codes MSB-first into bytes, stuffs 0x00 after 0xFF, 1-pads the tail.
// Define JPEG_STUFF_EOI_EN to append the FF D9 end-of-image marker after each frame.
module jpeg_byte_stuffer #(
  parameter int ACC_W   = 32,
  parameter int MAX_LEN = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_code,
  input  logic [4:0]  in_len,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_last
);

  localparam int CW = $clog2(ACC_W + 1);

`ifdef JPEG_STUFF_EOI_EN
  localparam logic DATA_LAST = 1'b0;
  typedef enum logic [2:0] {RUN, STUFF, FLUSH, DONE, EOI_FF, EOI_D9} state_t;
`else
  localparam logic DATA_LAST = 1'b1;
  typedef enum logic [2:0] {RUN, STUFF, FLUSH, DONE} state_t;
`endif

  state_t           state_reg;
  state_t           stuff_ret_reg;
  logic             stuff_last_reg;
  logic [ACC_W-1:0] acc_reg;
  logic [CW-1:0]    cnt_reg;
  logic             ready_en_reg;
  logic             out_valid_reg;
  logic [7:0]       out_data_reg;
  logic             out_last_reg;

  logic             accept;
  logic             last_in;
  logic             load_ok;
  logic [ACC_W-1:0] len_mask;
  logic [ACC_W-1:0] code_ext;
  logic [ACC_W-1:0] acc_app;
  logic [CW-1:0]    cnt_app;
  logic [CW:0]      sh;
  logic [7:0]       top_app;
  logic [7:0]       top_reg;
  logic [7:0]       pad_byte;
  logic [7:0]       flush_byte;
  logic             flush_end;

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_last  = out_last_reg;

  assign in_ready = ready_en_reg && (state_reg == RUN) &&
                    (cnt_reg <= CW'(ACC_W - MAX_LEN));
  assign accept   = in_valid && in_ready;
  assign last_in  = accept && in_last;
  assign load_ok  = !out_valid_reg || out_ready;

  for (genvar gi = 0; gi < ACC_W; gi++) begin : g_mask
    assign len_mask[gi] = (32'(gi) < 32'(in_len));
  end

  // The accumulator is MSB-aligned: the top cnt bits are valid, everything below is zero.
  assign code_ext = ACC_W'(in_code) & len_mask;
  assign sh       = (CW+1)'(ACC_W) - {1'b0, cnt_reg} - (CW+1)'(in_len);
  assign acc_app  = accept ? (acc_reg | (code_ext << sh)) : acc_reg;
  assign cnt_app  = accept ? (cnt_reg + CW'(in_len)) : cnt_reg;
  assign top_app  = acc_app[ACC_W-1 -: 8];
  assign top_reg  = acc_reg[ACC_W-1 -: 8];
  assign pad_byte = top_reg | (8'hFF >> cnt_reg[2:0]);

  assign flush_byte = (cnt_reg >= CW'(8)) ? top_reg : pad_byte;
  assign flush_end  = (cnt_reg <= CW'(8));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= RUN;
      stuff_ret_reg  <= RUN;
      stuff_last_reg <= 1'b0;
      acc_reg        <= '0;
      cnt_reg        <= '0;
      ready_en_reg   <= 1'b0;
      out_valid_reg  <= 1'b0;
      out_data_reg   <= 8'h00;
      out_last_reg   <= 1'b0;
    end else begin
      ready_en_reg <= 1'b1;
      acc_reg      <= acc_app;
      cnt_reg      <= cnt_app;
      if (load_ok) out_valid_reg <= 1'b0;

      case (state_reg)
        RUN: begin
          // Popping from the merged view lets a wide code reach the output next cycle.
          if (load_ok && (cnt_app >= CW'(8))) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= top_app;
            acc_reg       <= acc_app << 8;
            cnt_reg       <= cnt_app - CW'(8);
            if (top_app == 8'hFF) begin
              out_last_reg   <= 1'b0;
              state_reg      <= STUFF;
              stuff_ret_reg  <= last_in ? FLUSH : RUN;
              stuff_last_reg <= last_in && (cnt_app == CW'(8));
            end else begin
              out_last_reg <= DATA_LAST && last_in && (cnt_app == CW'(8));
              if (last_in) state_reg <= FLUSH;
            end
          end else if (last_in) begin
            state_reg <= FLUSH;
          end
        end
        STUFF: begin
          if (load_ok) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= 8'h00;
            out_last_reg  <= DATA_LAST && stuff_last_reg;
            state_reg     <= stuff_ret_reg;
          end
        end
        FLUSH: begin
          if (cnt_reg == '0) begin
`ifdef JPEG_STUFF_EOI_EN
            state_reg <= EOI_FF;
`else
            state_reg <= DONE;
`endif
          end else if (load_ok) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= flush_byte;
            acc_reg       <= acc_reg << 8;
            cnt_reg       <= flush_end ? '0 : (cnt_reg - CW'(8));
            if (flush_byte == 8'hFF) begin
              out_last_reg   <= 1'b0;
              state_reg      <= STUFF;
              stuff_ret_reg  <= FLUSH;
              stuff_last_reg <= flush_end;
            end else begin
              out_last_reg <= DATA_LAST && flush_end;
            end
          end
        end
`ifdef JPEG_STUFF_EOI_EN
        EOI_FF: begin
          if (load_ok) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= 8'hFF;
            out_last_reg  <= 1'b0;
            state_reg     <= EOI_D9;
          end
        end
        EOI_D9: begin
          if (load_ok) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= 8'hD9;
            out_last_reg  <= 1'b1;
            state_reg     <= DONE;
          end
        end
`endif
        DONE: begin
          acc_reg   <= '0;
          cnt_reg   <= '0;
          state_reg <= RUN;
        end
        default: state_reg <= RUN;
      endcase
    end
  end

endmodule
